// File: rtl/complex_div_operand_collector.sv
// Operand collector feeding complex_div: gathers a, b, c, d words from a
// valid/ready stream into one packed set, with one set assembling while the
// previous one waits in the output slot for the divider.
module complex_div_operand_collector #(
  parameter int WIDTH        = 64,
  parameter int NUM_OPERANDS = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic                                  word_valid_i,
  output logic                                  word_ready_o,
  input  logic [WIDTH-1:0]                      word_i,
  output logic                                  out_valid_o,
  input  logic                                  out_ready_i,
  output logic [NUM_OPERANDS-1:0][WIDTH-1:0]    operands_o,
  output logic                                  zero_div_o,
  output logic [$clog2(NUM_OPERANDS)-1:0]       count_o,
  output logic                                  busy_o
);

  localparam int CW = $clog2(NUM_OPERANDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_OPERANDS - 1);
  localparam int C_IDX = NUM_OPERANDS - 2;
  localparam int D_IDX = NUM_OPERANDS - 1;

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                            state;
  logic [CW-1:0]                     cnt;
  logic [WIDTH-1:0]                  asm_q [NUM_OPERANDS-1];
  logic [WIDTH-1:0]                  asm_last;
  logic                              asm_full;
  logic                              slot_free;
  logic                              accept;
  logic [NUM_OPERANDS-1:0][WIDTH-1:0] direct_set;
  logic [NUM_OPERANDS-1:0][WIDTH-1:0] hold_set;

  // Divisor component is zero when everything except the sign bit is clear.
  function automatic logic is_zero(input logic [WIDTH-1:0] x);
    return x[WIDTH-2:0] == '0;
  endfunction

  assign asm_full     = (state == HOLD);
  assign word_ready_o = !asm_full && !flush_i;
  assign accept       = word_valid_i && word_ready_o;
  assign slot_free    = !out_valid_o || out_ready_i;
  assign count_o      = cnt;
  assign busy_o       = (cnt != '0) || asm_full || out_valid_o;

  // Candidate sets: completing word straight from the input, or the parked last word.
  always_comb begin
    direct_set = '0;
    hold_set   = '0;
    for (int i = 0; i < NUM_OPERANDS - 1; i++) begin
      direct_set[i] = asm_q[i];
      hold_set[i]   = asm_q[i];
    end
    direct_set[D_IDX] = word_i;
    hold_set[D_IDX]   = asm_last;
  end

  // Assembly/hold state machine and the registered output slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= COLLECT;
      cnt         <= '0;
      asm_last    <= '0;
      for (int i = 0; i < NUM_OPERANDS - 1; i++) asm_q[i] <= '0;
      out_valid_o <= 1'b0;
      zero_div_o  <= 1'b0;
      operands_o  <= '0;
    end else if (flush_i) begin
      state       <= COLLECT;
      cnt         <= '0;
      out_valid_o <= 1'b0;
    end else begin
      if (out_valid_o && out_ready_i) out_valid_o <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            if (cnt != LAST_IDX) begin
              for (int i = 0; i < NUM_OPERANDS - 1; i++)
                if (cnt == CW'(i)) asm_q[i] <= word_i;
              cnt <= cnt + 1'b1;
            end else if (slot_free) begin
              operands_o  <= direct_set;
              zero_div_o  <= is_zero(direct_set[C_IDX]) && is_zero(direct_set[D_IDX]);
              out_valid_o <= 1'b1;
              cnt         <= '0;
            end else begin
              asm_last <= word_i;
              state    <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            operands_o  <= hold_set;
            zero_div_o  <= is_zero(hold_set[C_IDX]) && is_zero(hold_set[D_IDX]);
            out_valid_o <= 1'b1;
            cnt         <= '0;
            state       <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/complex_div_operand_collector.md
# complex_div_operand_collector

Upstream feeder for `complex_div`. It accepts IEEE-754 operand words one per cycle over a valid/ready stream and assembles them into the packed operand bundle `{a, b, c, d}` that the divider consumes as `operands_i`. The set represents the division (a + jb)/(c + jd). The block holds two sets at most, one assembling and one presented, so collection of the next division overlaps with a stalled divider. It also raises a registered divide-by-zero flag with each presented set.

## Interface
Parameters:
- `WIDTH`, 64: operand word width in bits (binary64).
- `NUM_OPERANDS`, 4: words per set, in the order a, b, c, d.

Ports:
- `clk_i`  in  1  Single clock. All logic is on the rising edge.
- `rst_i`  in  1  Reset, asynchronous and active-high.
- `flush_i`  in  1  Synchronous clear of all in-flight state.
- `word_valid_i`  in  1  Upstream word valid.
- `word_ready_o`  out  1  Collector can accept a word.
- `word_i`  in  WIDTH  Operand word.
- `out_valid_o`  out  1  A complete set is presented. Connects to divider `in_valid_i`.
- `out_ready_i`  in  1  Divider accepts. Connects to divider `in_ready_o`.
- `operands_o`  out  NUM_OPERANDS×WIDTH  Packed set. Index 0 = a, 1 = b, 2 = c, 3 = d.
- `zero_div_o`  out  1  Presented divisor is zero: `operands_o[2]` and `operands_o[3]` both ±0.
- `count_o`  out  $clog2(NUM_OPERANDS)  Number of words held in the assembly buffer.
- `busy_o`  out  1  `count_o != 0`, or the assembly buffer is full, or `out_valid_o`.

## Operation
- Storage:
  - Assembly registers `asm[0..NUM_OPERANDS-2]`.
  - Word counter `cnt`.
  - `asm_full` flag, which holds all NUM_OPERANDS words in `asm` plus `asm_last`.
  - Output slot: `operands_o`, `zero_div_o`, `out_valid_o`.
- A word is accepted when `word_valid_i && word_ready_o`.
- Output slot free this cycle: `slot_free = !out_valid_o || out_ready_i`.
- `word_ready_o = !asm_full && !flush_i`. This is combinational and has no dependency on `word_valid_i`.
- States:
  - COLLECT (`asm_full=0`)
    - An accepted word with `cnt < NUM_OPERANDS-1` writes `asm[cnt]` and increments `cnt`.
    - An accepted word with `cnt == NUM_OPERANDS-1` completes the set. If `slot_free`, load the output slot directly with `{asm[0..2], word_i}`, set `out_valid_o=1`, and set `cnt=0`. Otherwise store the word in `asm_last`, set `asm_full=1`, and go to HOLD.
  - HOLD (`asm_full=1`)
    - Input is stalled.
    - When `out_ready_i` is high, load the output slot from `asm`/`asm_last` in the same edge, keep `out_valid_o=1`, clear `asm_full`, set `cnt=0`, and return to COLLECT.
- When the output handshake completes and no new set is loaded, `out_valid_o` drops to 0 on the next edge.
- While `out_valid_o=1 && !out_ready_i`, `operands_o` and `zero_div_o` hold stable.
- `zero_div_o` is computed from the loaded c and d, ignoring the sign bit: `x[WIDTH-2:0]==0`. It is registered together with `operands_o`. NaN and denormal inputs are not flagged.
- Flush: on an edge with `flush_i=1`, clear `cnt`, `asm_full` and `out_valid_o`. Any word offered in that cycle is not accepted. Any set being handed over is dropped.
- Reset values:
  - `out_valid_o`, `zero_div_o`, `count_o`, `busy_o` = 0.
  - `operands_o` = 0.
  - `word_ready_o` = 1 once `rst_i` deasserts.
- Reset asserted mid-set or mid-HOLD discards everything immediately, asynchronously.

## Timing
- Latency: the 4th word is accepted at edge N, and `out_valid_o` is high after edge N with that set.
- Throughput: one set per NUM_OPERANDS cycles with no input bubbles when `out_ready_i` stays high.
- Simultaneous completion and output handshake: the new set replaces the old one in the same edge, and `out_valid_o` stays high.
- Maximum buffering is two complete sets: one in the output slot and one in HOLD.
- `word_ready_o` falls in the cycle after the edge that enters HOLD.
- `word_ready_o` rises in the cycle after the edge in which HOLD drains.

## Test plan
- **Single set.** Feed a=0x401C000000000000 (7.0), b=0x4000000000000000 (2.0), c=0x3FF0000000000000 (1.0), d=0x4000000000000000 (2.0) with `out_ready_i=1`.
  - Required: `out_valid_o` high for exactly one cycle, after the 4th accept edge.
  - `operands_o` = {7.0, 2.0, 1.0, 2.0} in index order; `zero_div_o`=0.
- **Back-to-back.** Feed 3 sets continuously with `out_ready_i=1`.
  - Required: `word_ready_o` is never low.
  - `out_valid_o` pulses every 4th cycle, with the sets in order.
- **Backpressure.** Feed 2 sets with `out_ready_i=0`.
  - Required: set 1 is held stable, and `word_ready_o` is low after the 8th word.
  - Raise `out_ready_i` for one cycle: set 2 is presented, and `word_ready_o` returns high the following cycle.
- **Zero divisor.** Use c=0x8000000000000000, d=0x0000000000000000.
  - Required: `zero_div_o`=1 with the set.
  - A following set with d=1.0 gives `zero_div_o`=0.
- **Flush.** Assert `flush_i` after 2 words, then feed a full set.
  - Required: `count_o`=0 after the flush edge.
  - The presented set contains only the 4 post-flush words.
- **Reset mid-HOLD.** With two sets buffered, pulse `rst_i` between edges.
  - Required: `out_valid_o`, `count_o` and `busy_o` go to 0 immediately.
  - `word_ready_o`=1 after release, and the next full set is presented normally.
